// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: register/Tnew widths and MDU start encodings.
package mips_defs;

  localparam int unsigned RAW = 5;
  localparam int unsigned TW  = 2;

  // Tuse value meaning "operand not read"
  localparam logic [TW-1:0] TUSE_NONE = '1;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

endpackage

// File: rtl/md_busy_ctr.sv
// Mult/div busy counter: loads the unit latency on a start and counts down to idle.
module md_busy_ctr
  import mips_defs::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] md_start,
  output logic       md_busy
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] bcnt;

  // Reload on start (11 is treated as div), otherwise count down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= '0;
    end else begin
      case (md_start)
        MD_MUL:  bcnt <= CW'(MUL_LAT);
        MD_NONE: if (bcnt != '0) bcnt <= bcnt - CW'(1);
        default: bcnt <= CW'(DIV_LAT);
      endcase
    end
  end

  assign md_busy = (bcnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward unit: tracks in-flight destinations with their Tnew countdown,
// raises stall against decode Tuse, and picks the D-stage forwarding source.
module hazard_scoreboard
  import mips_defs::*;
#(
  parameter int unsigned NSTAGE  = 3,
  parameter int unsigned RAW     = mips_defs::RAW,
  parameter int unsigned TW      = mips_defs::TW,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  localparam int unsigned SW     = $clog2(NSTAGE + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [RAW-1:0] d_rs,
  input  logic [RAW-1:0] d_rt,
  input  logic [TW-1:0]  d_tuse_rs,
  input  logic [TW-1:0]  d_tuse_rt,
  input  logic [RAW-1:0] d_a3,
  input  logic [TW-1:0]  d_tnew,
  input  logic           d_is_md,
  input  logic [1:0]     e_md_start,
  input  logic           flush,
  output logic           stall,
  output logic [SW-1:0]  fwd_rs_sel,
  output logic [SW-1:0]  fwd_rt_sel,
  output logic           md_busy
);

  localparam logic [TW-1:0] TUSE_OFF = '1;

  logic [RAW-1:0]    ent_a3   [NSTAGE];
  logic [TW-1:0]     ent_tnew [NSTAGE];
  logic [NSTAGE-1:0] hit_rs, hit_rt, stl_rs, stl_rt;
  logic              rs_read, rt_read, md_stall;

  assign rs_read = (d_tuse_rs != TUSE_OFF);
  assign rt_read = (d_tuse_rt != TUSE_OFF);

  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_start (e_md_start),
    .md_busy  (md_busy)
  );

  // E entry: take the decode instruction unless it is stalled or killed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_a3[0]   <= '0;
      ent_tnew[0] <= '0;
    end else if (stall || flush) begin
      ent_a3[0]   <= '0;
      ent_tnew[0] <= '0;
    end else begin
      ent_a3[0]   <= d_a3;
      ent_tnew[0] <= d_tnew;
    end
  end

  // Later stages always advance, Tnew counting down and saturating at zero
  for (genvar k = 1; k < NSTAGE; k++) begin : g_shift
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ent_a3[k]   <= '0;
        ent_tnew[k] <= '0;
      end else begin
        ent_a3[k]   <= ent_a3[k-1];
        ent_tnew[k] <= (ent_tnew[k-1] != '0) ? ent_tnew[k-1] - TW'(1) : '0;
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_cmp
    assign hit_rs[k] = (ent_a3[k] == d_rs) && (d_rs != '0);
    assign hit_rt[k] = (ent_a3[k] == d_rt) && (d_rt != '0);
    assign stl_rs[k] = hit_rs[k] && rs_read && (ent_tnew[k] > d_tuse_rs);
    assign stl_rt[k] = hit_rt[k] && rt_read && (ent_tnew[k] > d_tuse_rt);
  end

  assign md_stall = d_is_md && (md_busy || (e_md_start != MD_NONE));

  // Stall on any unresolved RAW dependency or a dependent MD instruction
  always_comb begin
    stall = (|stl_rs) || (|stl_rt) || md_stall;
  end

  // Only the youngest match decides; a not-ready youngest entry must not
  // fall through to an older stage holding a stale value
  always_comb begin
    logic found_rs, found_rt;
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    found_rs   = 1'b0;
    found_rt   = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (!found_rs && hit_rs[i]) begin
        found_rs   = 1'b1;
        fwd_rs_sel = (ent_tnew[i] == '0) ? SW'(i + 1) : '0;
      end
      if (!found_rt && hit_rt[i]) begin
        found_rt   = 1'b1;
        fwd_rt_sel = (ent_tnew[i] == '0) ? SW'(i + 1) : '0;
      end
    end
  end

endmodule
